// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART TX arbiter.
// The FSM encoding is fixed so debug taps read the same across builds.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int gap, input int tmo);
    int m;
    m = (gap > tmo) ? gap : tmo;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or above ptr, with wrap.
// Purely combinational; the caller owns the pointer register.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] pick,
  output logic          any
);

  always_comb begin
    pick = '0;
    any  = |req;
    // Walk offsets downward so the smallest offset wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        pick = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter in front of the UART TX byte channel,
// with an inter-packet idle gap and a mid-packet stall watchdog.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int GAP_CYC = 16,
  parameter int TMO_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req_vld,
  input  logic [NREQ*DW-1:0]        req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_rdy,
  output logic                      tx_vld,
  output logic [DW-1:0]             tx_data,
  input  logic                      tx_rdy,
  output logic [idx_w(NREQ)-1:0]    gnt_id,
  output logic                      busy,
  output logic                      tmo_err
);

  localparam int IW    = idx_w(NREQ);
  localparam int CW    = cnt_w(GAP_CYC, TMO_CYC);
  localparam int GAP_L = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  localparam logic [CW-1:0] TMO_T = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] GAP_T = CW'(GAP_L);
  localparam logic [CW-1:0] C_MAX = '1;

  localparam arb_state_t POST = (GAP_CYC == 0) ? IDLE : GAP;

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] pick;
  logic [IW-1:0] nxt;
  logic [CW-1:0] cnt;
  logic          any;
  logic          vld_g;
  logic          last_g;
  logic          beat;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req  (req_vld),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  assign nxt    = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
  assign vld_g  = req_vld[gnt_id];
  assign last_g = req_last[gnt_id];
  assign beat   = (state == XFER) && vld_g && tx_rdy;
  assign busy   = (state != IDLE);

  // One counter serves as stall timer in XFER and gap timer in GAP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      gnt_id  <= '0;
      ptr     <= '0;
      cnt     <= '0;
      tmo_err <= 1'b0;
    end else begin
      tmo_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt_id <= pick;
            ptr    <= nxt;
            cnt    <= '0;
            state  <= XFER;
          end
        end
        XFER: begin
          if (beat && last_g) begin
            cnt   <= '0;
            state <= POST;
          end else if (!vld_g && cnt == TMO_T) begin
            tmo_err <= 1'b1;
            cnt     <= '0;
            state   <= POST;
          end else if (vld_g) begin
            cnt <= '0;
          end else if (cnt != C_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_T) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt != C_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    tx_vld  = 1'b0;
    tx_data = '0;
    req_rdy = '0;
    if (state == XFER) begin
      tx_vld          = vld_g;
      tx_data         = req_data[gnt_id*DW +: DW];
      req_rdy[gnt_id] = tx_rdy;
    end
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares the single UART transmit byte channel of `uart_top` between NREQ independent requesters. A requester holds the channel for a whole packet (terminated by its `last` flag). The arbiter then enforces a fixed idle gap before regranting. A stall watchdog reclaims the channel from a requester that stops supplying bytes mid-packet.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8
- DW, 8: data width, matches the UART TX byte
- GAP_CYC, 16: idle cycles inserted after each packet; 0 = no gap
- TMO_CYC, 1024: consecutive stall cycles mid-packet before forced release, ≥ 2

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- req_vld  in  NREQ  per-requester byte valid
- req_data  in  NREQ*DW  per-requester byte; requester i on bits [i*DW +: DW]
- req_last  in  NREQ  marks final byte of the packet
- req_rdy  out  NREQ  per-requester accept
- tx_vld  out  1  byte valid to UART TX
- tx_data  out  DW  byte to UART TX
- tx_rdy  in  1  UART TX can accept a byte this cycle
- gnt_id  out  clog2(NREQ)  current/last grantee index
- busy  out  1  arbiter is in XFER or GAP
- tmo_err  out  1  one-cycle pulse on watchdog release

## Operation
- FSM states: IDLE, XFER, GAP.
- IDLE:
  - If any req_vld is set, pick the first set bit searching upward (with wrap) from `ptr`.
  - Register gnt_id = pick and set ptr = pick+1 mod NREQ.
  - Go to XFER.
- XFER:
  - tx_vld = req_vld[gnt_id], tx_data = req_data[gnt_id], req_rdy[gnt_id] = tx_rdy.
  - All other req_rdy bits are 0.
  - A beat is a cycle with tx_vld && tx_rdy.
  - A beat with req_last[gnt_id] = 1 ends the packet. Go to GAP, or to IDLE if GAP_CYC = 0.
- Watchdog:
  - Runs in XFER. The stall counter increments every cycle with req_vld[gnt_id] = 0 and clears on any cycle with req_vld[gnt_id] = 1.
  - When the counter reaches TMO_CYC-1 while still stalled, pulse tmo_err for one cycle and go to GAP (or IDLE).
  - The partial packet is abandoned; no byte is fabricated.
- GAP:
  - tx_vld = 0 and all req_rdy = 0.
  - The gap counter runs from 0 to GAP_CYC-1, then the FSM returns to IDLE.
- Outputs in IDLE and GAP: tx_vld = 0, req_rdy = 0, tx_data = 0.
- busy = (state != IDLE).
- ptr is reset to 0. Reset value of gnt_id is 0.
- Widths: counters are sized clog2(max(GAP_CYC,TMO_CYC)+1) and never wrap; they saturate at their terminal count and are cleared on state entry.

## Timing
- Arbitration latency: a request seen in IDLE at cycle n reaches XFER at n+1. tx_vld can therefore first assert at n+1.
- The data path is combinational from req_* to tx_* in XFER only. There is no added byte latency.
- Packet turnaround: the last beat at cycle m puts the FSM in GAP at m+1. The FSM reaches IDLE at m+1+GAP_CYC, and the next grant takes effect one cycle later.
- Back-to-back packets from the same requester are still separated by the gap and by re-arbitration. Round-robin moves on to the next active requester.
- A requester that drops req_vld mid-packet keeps its grant until its last beat or until the watchdog fires.
- Simultaneous events:
  - A final beat and watchdog expiry cannot coincide, because a beat clears stall.
  - req_vld changing while IDLE is sampled only at the decision edge.
- Reset asserted mid-packet: all outputs go immediately (asynchronously) to reset values and the FSM returns to IDLE.
- Reset values: req_rdy = 0, tx_vld = 0, tx_data = 0, gnt_id = 0, busy = 0, tmo_err = 0.

## Structure
- Package `uart_arb_pkg`: FSM state enumeration (IDLE = 0, XFER = 1, GAP = 2) and width helper constants derived from NREQ, GAP_CYC and TMO_CYC.
- Sub-module `rr_pick`: purely combinational rotate-priority encoder. Inputs are the req vector and ptr; outputs are the pick index and an any-flag. The FSM, counters and muxes remain in `uart_tx_arb`.
- Placement: instantiated above `uart_top`; tx_* connects to its transmit-FIFO write side.

## Test plan
- Single requester: req 0 sends 3 bytes 0x5B, 0xA5, 0x3C with last on 0x3C and tx_rdy = 1.
  - Expect 3 consecutive beats, gnt_id = 0, then busy held for 16 cycles of GAP, then IDLE.
- Contention: all 4 requesters hold 1-byte packets valid (data 0x10+i).
  - Expect tx_data order 0x10, 0x11, 0x12, 0x13, 0x10.
  - Each grant is separated by 16+1 idle cycles.
- Backpressure: tx_rdy toggles 1,0,1,0 during a 4-byte packet from req 2.
  - Expect each byte held stable on tx_data while tx_rdy = 0.
  - Expect no duplication and req_rdy[2] to mirror tx_rdy.
- Watchdog: req 1 sends 1 byte without last, then deasserts req_vld.
  - Expect a tmo_err pulse exactly TMO_CYC cycles after the deassert, then GAP.
  - Req 3 is then granted.
- Reset mid-packet: assert rstn = 0 during the second byte of a packet.
  - Expect tx_vld = 0, req_rdy = 0 and busy = 0 immediately.
  - After release, the first grant goes to the lowest active index (ptr = 0).
- GAP_CYC = 0 build: two requesters with 1-byte packets.
  - Expect grants separated by exactly one IDLE cycle.
